// File: rtl/spring_launch_controller_pkg.sv
// Shared types and default constants for the plunger launch controller.
// Parameters of the top module default to the constants defined here.
package spring_launch_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COMPRESSING,
    RELEASING,
    LAUNCH,
    COOLDOWN
  } launch_state_t;

  localparam int DEF_SPRING_REST_Y   = 430;
  localparam int DEF_MIN_COMPRESSION = 4;
  localparam int DEF_MAX_COMPRESSION = 40;
  localparam int DEF_LAUNCH_BASE     = 64;
  localparam int DEF_LAUNCH_GAIN     = 8;
  localparam int DEF_RELEASE_TIMEOUT = 60;
  localparam int DEF_COOLDOWN_FRAMES = 30;

  localparam int COMP_W = 6;
  localparam int CNT_W  = 8;

  // Pull distance below rest, clamped to [0, max_c]; a spring above rest reads as 0.
  function automatic logic [COMP_W-1:0] clamp_compression(
    input logic signed [10:0] y,
    input int                 rest,
    input int                 max_c
  );
    int diff;
    diff = int'(y) - rest;
    if (diff < 0) begin
      return '0;
    end else if (diff > max_c) begin
      return COMP_W'(max_c);
    end else begin
      return COMP_W'(diff);
    end
  endfunction

endpackage

// File: rtl/spring_launch_controller_frame_counter.sv
// Frame counter shared by the RELEASING and COOLDOWN phases: counts enabled
// frame strobes, clears synchronously and flags when the terminal count is reached.
module spring_launch_controller_frame_counter
  import spring_launch_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] terminal_i,
  output logic             terminal_o
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign terminal_o = (count_q == terminal_i);

endmodule

// File: rtl/spring_launch_controller.sv
// Turns a plunger pull-and-release into a single one-cycle ball launch whose
// upward speed scales with the peak compression seen while the key was held.
module spring_launch_controller
  import spring_launch_controller_pkg::*;
#(
  parameter int SPRING_REST_Y   = DEF_SPRING_REST_Y,
  parameter int MIN_COMPRESSION = DEF_MIN_COMPRESSION,
  parameter int MAX_COMPRESSION = DEF_MAX_COMPRESSION,
  parameter int LAUNCH_BASE     = DEF_LAUNCH_BASE,
  parameter int LAUNCH_GAIN     = DEF_LAUNCH_GAIN,
  parameter int RELEASE_TIMEOUT = DEF_RELEASE_TIMEOUT,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        key5IsPressed,
  input  logic [10:0] springTopLeftY,
  input  logic [31:0] springSpeedY,
  input  logic        ballInLane,
  output logic        launchPulse,
  output logic [31:0] launchSpeedY,
  output logic [5:0]  compression,
  output logic        armed
);

  localparam logic signed [10:0] REST_Y    = 11'(SPRING_REST_Y);
  localparam logic [COMP_W-1:0]  MIN_C     = COMP_W'(MIN_COMPRESSION);
  localparam logic [CNT_W-1:0]   REL_TERM  = CNT_W'(RELEASE_TIMEOUT);
  localparam logic [CNT_W-1:0]   COOL_TERM = CNT_W'(COOLDOWN_FRAMES);
  localparam logic signed [31:0] BASE_S    = 32'(LAUNCH_BASE);
  localparam logic signed [31:0] GAIN_S    = 32'(LAUNCH_GAIN);

  launch_state_t      state_q, state_d;
  logic [COMP_W-1:0]  peak_q, peak_d;
  logic [COMP_W-1:0]  compression_q, compression_d;
  logic               launch_pulse_q;
  logic signed [31:0] launch_speed_q, launch_speed_d;
  logic               armed_q;

  logic [COMP_W-1:0]  peak_max;
  logic signed [31:0] peak_ext;
  logic               spring_at_rest;
  logic               cnt_clear, cnt_en, cnt_terminal;
  logic [CNT_W-1:0]   cnt_terminal_value;

  // Speed is observed only; release timing depends purely on position and frames.
  logic spring_speed_unused;
  assign spring_speed_unused = ^springSpeedY;

  assign compression_d  = clamp_compression($signed(springTopLeftY), SPRING_REST_Y,
                                            MAX_COMPRESSION);
  assign spring_at_rest = ($signed(springTopLeftY) <= REST_Y);
  assign peak_max       = (compression_q > peak_q) ? compression_q : peak_q;
  assign peak_ext       = {{(32-COMP_W){1'b0}}, peak_q};
  assign launch_speed_d = -(BASE_S + GAIN_S * peak_ext);

  assign cnt_en             = startOfFrame && ((state_q == RELEASING) || (state_q == COOLDOWN));
  assign cnt_terminal_value = (state_q == RELEASING) ? REL_TERM : COOL_TERM;

  spring_launch_controller_frame_counter u_frame_counter (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .enable_i   (cnt_en),
    .terminal_i (cnt_terminal_value),
    .terminal_o (cnt_terminal)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    peak_d    = peak_q;
    cnt_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (startOfFrame && ballInLane) state_d = ARMED;
      end
      ARMED: begin
        if (startOfFrame) begin
          if (!ballInLane) begin
            state_d = IDLE;
          end else if (key5IsPressed) begin
            state_d = COMPRESSING;
            peak_d  = '0;
          end
        end
      end
      COMPRESSING: begin
        if (startOfFrame) begin
          if (!ballInLane) begin
            state_d = IDLE;
            peak_d  = '0;
          end else begin
            peak_d = peak_max;
            if (!key5IsPressed) begin
              if (peak_max >= MIN_C) begin
                state_d   = RELEASING;
                cnt_clear = 1'b1;
              end else begin
                state_d = ARMED;
              end
            end
          end
        end
      end
      RELEASING: begin
        // A re-press resumes the pull with the peak kept; lane changes are ignored here.
        if (startOfFrame) begin
          if (key5IsPressed) begin
            state_d = COMPRESSING;
          end else if (spring_at_rest || cnt_terminal) begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_d   = COOLDOWN;
        cnt_clear = 1'b1;
      end
      COOLDOWN: begin
        if (startOfFrame && cnt_terminal) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        peak_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      peak_q         <= '0;
      compression_q  <= '0;
      launch_pulse_q <= 1'b0;
      launch_speed_q <= '0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      peak_q         <= peak_d;
      compression_q  <= compression_d;
      launch_pulse_q <= (state_d == LAUNCH);
      armed_q        <= (state_d == ARMED) || (state_d == COMPRESSING);
      if (state_d == LAUNCH) launch_speed_q <= launch_speed_d;
    end
  end

  assign launchPulse  = launch_pulse_q;
  assign launchSpeedY = launch_speed_q;
  assign compression  = compression_q;
  assign armed        = armed_q;

endmodule

// File: tb/tb_spring_launch_controller.sv
// Directed bench for spring_launch_controller: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_spring_launch_controller;

  logic        clk;
  logic        reset;
  logic        startOfFrame;
  logic        key5IsPressed;
  logic [10:0] springTopLeftY;
  logic [31:0] springSpeedY;
  logic        ballInLane;
  logic        launchPulse;
  logic [31:0] launchSpeedY;
  logic [5:0]  compression;
  logic        armed;

  int tests_run;
  int tests_failed;

  int          pulse_count;
  int          cur_width;
  int          max_width;
  logic [31:0] last_speed;

  spring_launch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .key5IsPressed  (key5IsPressed),
    .springTopLeftY (springTopLeftY),
    .springSpeedY   (springSpeedY),
    .ballInLane     (ballInLane),
    .launchPulse    (launchPulse),
    .launchSpeedY   (launchSpeedY),
    .compression    (compression),
    .armed          (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts launches, records the widest pulse and the speed it carried.
  initial begin
    pulse_count = 0;
    cur_width   = 0;
    max_width   = 0;
    last_speed  = '0;
  end

  always @(negedge clk) begin
    if (launchPulse === 1'b1) begin
      pulse_count = pulse_count + 1;
      cur_width   = cur_width + 1;
      last_speed  = launchSpeedY;
      if (cur_width > max_width) max_width = cur_width;
    end else begin
      cur_width = 0;
    end
  end

  task automatic frame();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (launchPulse !== 1'b0) begin tests_failed++; $display("FAIL reset_pulse: got %b, expected 0", launchPulse); end
    tests_run++; if (launchSpeedY !== 32'd0) begin tests_failed++; $display("FAIL reset_speed: got %0d, expected 0", $signed(launchSpeedY)); end
    tests_run++; if (compression !== 6'd0) begin tests_failed++; $display("FAIL reset_compression: got %0d, expected 0", compression); end
    tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL reset_armed: got %b, expected 0", armed); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_compression();
    int ys  [6] = '{450, 431, 470, 500, 429, -100};
    int exps[6] = '{20,  1,   40,  40,  0,   0};
    for (int i = 0; i < 6; i++) begin
      springTopLeftY = 11'(ys[i]);
      @(negedge clk);
      tests_run++;
      if (compression !== 6'(exps[i])) begin
        tests_failed++;
        $display("FAIL compression_y%0d: got %0d, expected %0d", ys[i], compression, exps[i]);
      end
    end
    springTopLeftY = 11'd430;
    @(negedge clk);
  endtask

  task automatic test_full_launch();
    int p0;
    ballInLane = 1'b1;
    frame();
    tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL full_armed: got %b, expected 1", armed); end
    key5IsPressed = 1'b1;
    frame();
    for (int k = 1; k <= 10; k++) begin
      springTopLeftY = 11'(430 + 4 * k);
      frame();
    end
    tests_run++; if (compression !== 6'd40) begin tests_failed++; $display("FAIL full_peak_compression: got %0d, expected 40", compression); end
    p0 = pulse_count;
    key5IsPressed = 1'b0;
    frame();
    tests_run++; if (armed !== 1'b0 || pulse_count !== p0) begin tests_failed++; $display("FAIL full_releasing: armed %b pulses %0d, expected armed 0 pulses %0d", armed, pulse_count, p0); end
    springTopLeftY = 11'd430;
    frame();
    tests_run++; if (pulse_count !== p0 + 1) begin tests_failed++; $display("FAIL full_launch_count: got %0d, expected %0d", pulse_count, p0 + 1); end
    tests_run++; if (last_speed !== -32'sd384) begin tests_failed++; $display("FAIL full_launch_speed: got %0d, expected -384", $signed(last_speed)); end
    tests_run++; if (max_width !== 1) begin tests_failed++; $display("FAIL full_pulse_width: got %0d, expected 1", max_width); end
    tests_run++; if (launchSpeedY !== -32'sd384) begin tests_failed++; $display("FAIL full_speed_held: got %0d, expected -384", $signed(launchSpeedY)); end
    // Cooldown: key5 is pressed during the first 20 frames and must be ignored.
    key5IsPressed = 1'b1;
    frames(20);
    key5IsPressed = 1'b0;
    frames(10);
    tests_run++; if (armed !== 1'b0 || pulse_count !== p0 + 1) begin tests_failed++; $display("FAIL cooldown_30: armed %b pulses %0d, expected armed 0 pulses %0d", armed, pulse_count, p0 + 1); end
    frame();
    tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL cooldown_31_idle: got %b, expected 0", armed); end
    frame();
    tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL cooldown_rearm: got %b, expected 1", armed); end
  endtask

  task automatic test_min_boundary();
    int p0;
    p0 = pulse_count;
    key5IsPressed = 1'b1;
    frame();
    springTopLeftY = 11'd432;
    frame();
    key5IsPressed = 1'b0;
    frame();
    tests_run++; if (armed !== 1'b1 || pulse_count !== p0) begin tests_failed++; $display("FAIL small_pull: armed %b pulses %0d, expected armed 1 pulses %0d", armed, pulse_count, p0); end
    tests_run++; if (compression !== 6'd2) begin tests_failed++; $display("FAIL small_compression: got %0d, expected 2", compression); end
    key5IsPressed = 1'b1;
    frame();
    springTopLeftY = 11'd434;
    frame();
    key5IsPressed = 1'b0;
    frame();
    springTopLeftY = 11'd430;
    frame();
    tests_run++; if (pulse_count !== p0 + 1) begin tests_failed++; $display("FAIL min_pull_count: got %0d, expected %0d", pulse_count, p0 + 1); end
    tests_run++; if (last_speed !== -32'sd96) begin tests_failed++; $display("FAIL min_pull_speed: got %0d, expected -96", $signed(last_speed)); end
    frames(32);
    tests_run++; if (armed !== 1'b1) begin tests_failed++; $display("FAIL min_pull_rearm: got %b, expected 1", armed); end
  endtask

  task automatic test_forced_launch();
    int p0;
    p0 = pulse_count;
    springSpeedY = 32'd100;
    key5IsPressed = 1'b1;
    frame();
    springTopLeftY = 11'd450;
    frame();
    key5IsPressed = 1'b0;
    frame();
    springTopLeftY = 11'd440;
    frames(60);
    tests_run++; if (pulse_count !== p0 || armed !== 1'b0) begin tests_failed++; $display("FAIL forced_early: pulses %0d armed %b, expected pulses %0d armed 0", pulse_count, armed, p0); end
    frame();
    tests_run++; if (pulse_count !== p0 + 1) begin tests_failed++; $display("FAIL forced_count: got %0d, expected %0d", pulse_count, p0 + 1); end
    tests_run++; if (last_speed !== -32'sd224) begin tests_failed++; $display("FAIL forced_speed: got %0d, expected -224", $signed(last_speed)); end
    springSpeedY = 32'd0;
    springTopLeftY = 11'd430;
    frames(32);
    tests_run++; if (armed !== 1'b1 || max_width !== 1) begin tests_failed++; $display("FAIL forced_rearm: armed %b width %0d, expected armed 1 width 1", armed, max_width); end
  endtask

  task automatic test_lane_drop();
    int p0;
    p0 = pulse_count;
    key5IsPressed = 1'b1;
    frame();
    springTopLeftY = 11'd450;
    frame();
    ballInLane    = 1'b0;
    key5IsPressed = 1'b0;
    frame();
    tests_run++; if (armed !== 1'b0 || pulse_count !== p0) begin tests_failed++; $display("FAIL lane_drop: armed %b pulses %0d, expected armed 0 pulses %0d", armed, pulse_count, p0); end
    key5IsPressed = 1'b1;
    frame();
    tests_run++; if (armed !== 1'b0) begin tests_failed++; $display("FAIL idle_key_ignored: got %b, expected 0", armed); end
    key5IsPressed  = 1'b0;
    springTopLeftY = 11'd430;
    ballInLane     = 1'b1;
    frame();
    tests_run++; if (armed !== 1'b1 || pulse_count !== p0) begin tests_failed++; $display("FAIL lane_return: armed %b pulses %0d, expected armed 1 pulses %0d", armed, pulse_count, p0); end
  endtask

  task automatic test_reset_mid_release();
    int p0;
    p0 = pulse_count;
    key5IsPressed = 1'b1;
    frame();
    springTopLeftY = 11'd460;
    frame();
    key5IsPressed = 1'b0;
    frame();
    tests_run++; if (compression !== 6'd30) begin tests_failed++; $display("FAIL midrst_compression: got %0d, expected 30", compression); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++; if (launchPulse !== 1'b0 || launchSpeedY !== 32'd0) begin tests_failed++; $display("FAIL midrst_launch_outputs: pulse %b speed %0d, expected 0 0", launchPulse, $signed(launchSpeedY)); end
    tests_run++; if (compression !== 6'd0 || armed !== 1'b0) begin tests_failed++; $display("FAIL midrst_status_outputs: compression %0d armed %b, expected 0 0", compression, armed); end
    @(negedge clk);
    reset = 1'b0;
    springTopLeftY = 11'd430;
    frames(3);
    tests_run++; if (pulse_count !== p0 || armed !== 1'b1) begin tests_failed++; $display("FAIL midrst_after: pulses %0d armed %b, expected pulses %0d armed 1", pulse_count, armed, p0); end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    startOfFrame   = 1'b0;
    key5IsPressed  = 1'b0;
    springTopLeftY = 11'd430;
    springSpeedY   = 32'd0;
    ballInLane     = 1'b0;

    test_reset();
    test_compression();
    test_full_launch();
    test_min_boundary();
    test_forced_launch();
    test_lane_drop();
    test_reset_mid_release();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
